// File: rtl/dram_stream_reader_pkg.sv
// Shared widths, address type and sequencer states for the DRAM stream reader.
package dram_stream_reader_pkg;

  localparam int unsigned DRAM_ADDR_W = 17;
  localparam int unsigned DRAM_DATA_W = 8;

  typedef logic [DRAM_ADDR_W-1:0] dram_addr_t;
  typedef logic [DRAM_DATA_W-1:0] dram_data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/dram_stream_reader_if.sv
// Request, DRAM-port and output-stream signals of the DRAM stream reader.
interface dram_stream_reader_if;
  import dram_stream_reader_pkg::*;

  logic       start;
  dram_addr_t base_addr;
  dram_addr_t count;
  dram_addr_t stride;
  dram_addr_t mem_address;
  logic       mem_wren;
  dram_data_t mem_data;
  dram_data_t mem_q;
  dram_data_t out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  modport master (
    input  start, base_addr, count, stride, mem_q, out_ready,
    output mem_address, mem_wren, mem_data, out_data, out_valid, busy, done
  );

  modport slave (
    output start, base_addr, count, stride, mem_q, out_ready,
    input  mem_address, mem_wren, mem_data, out_data, out_valid, busy, done
  );

endinterface

// File: rtl/dram_stream_reader_stream_fifo.sv
// Synchronous FIFO whose head entry sits in registered outputs (rd_data/rd_valid).
// DEPTH must be a power of two and at least 2.
module stream_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [CNT_W-1:0] occ_after_pop;
  logic [CNT_W-1:0] occ_d;
  logic [WIDTH-1:0] head_d;

  // Next head: a push into an (about to be) empty FIFO bypasses the array.
  always_comb begin
    occ_after_pop = occupancy - CNT_W'(pop);
    occ_d         = occ_after_pop + CNT_W'(push);
    rd_ptr_d      = rd_ptr + PTR_W'(pop);
    head_d        = (occ_after_pop == '0) ? push_data : mem[rd_ptr_d];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr    <= rd_ptr_d;
      occupancy <= occ_d;
      rd_valid  <= (occ_d != '0);
      if (occ_d != '0) rd_data <= head_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dram_stream_reader.sv
// DRAM read sequencer: issues credit-limited reads and streams returned bytes in order.
// Build option DRAM_STREAM_STRIDE_EN honours the stride port; otherwise addresses step by 1.
module dram_stream_reader
  import dram_stream_reader_pkg::*;
#(
  parameter int unsigned READ_LAT   = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                  clock,
  input logic                  reset_n,
  dram_stream_reader_if.master bus
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  state_e            state_q;
  state_e            state_d;
  dram_addr_t        cur_addr;
  dram_addr_t        remaining;
  dram_addr_t        mem_address_q;
  dram_addr_t        addr_inc;
  logic [READ_LAT:0] tag_pipe;
  logic [CNT_W-1:0]  occupancy;
  dram_data_t        fifo_data;
  logic              fifo_valid;
  logic              pop;
  logic              issue;
  logic              load;
  logic              credit_ok;
  logic              final_pop;
  logic              zero_done_d;
  logic              zero_done_q;
  int unsigned       reserved;

  // Bit 0 of tag_pipe lines up with mem_address; the top bit lines up with valid mem_q.
  assign pop = fifo_valid & bus.out_ready;

  // FIFO slots already spoken for; a slot being popped this cycle may be reused.
  always_comb begin
    reserved = 32'(occupancy);
    for (int unsigned i = 0; i <= READ_LAT; i++) reserved = reserved + 32'(tag_pipe[i]);
    reserved  = reserved - 32'(pop);
    credit_ok = (reserved < FIFO_DEPTH);
  end

  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    load        = 1'b0;
    final_pop   = 1'b0;
    zero_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load = 1'b1;
          if (bus.count == '0) zero_done_d = 1'b1;
          else                 state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (remaining == DRAM_ADDR_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (tag_pipe == '0 && occupancy == CNT_W'(1) && pop) begin
          final_pop = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cur_addr      <= '0;
      remaining     <= '0;
      mem_address_q <= '0;
      tag_pipe      <= '0;
      zero_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      zero_done_q <= zero_done_d;
      tag_pipe    <= {tag_pipe[READ_LAT-1:0], issue};
      if (load) begin
        cur_addr  <= bus.base_addr;
        remaining <= bus.count;
      end else if (issue) begin
        mem_address_q <= cur_addr;
        cur_addr      <= cur_addr + addr_inc;
        remaining     <= remaining - DRAM_ADDR_W'(1);
      end
    end
  end

`ifdef DRAM_STREAM_STRIDE_EN
  dram_addr_t stride_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  stride_q <= '0;
    else if (load) stride_q <= bus.stride;
  end

  assign addr_inc = stride_q;
`else
  logic unused_stride;

  assign unused_stride = ^bus.stride;
  assign addr_inc      = DRAM_ADDR_W'(1);
`endif

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DRAM_DATA_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (tag_pipe[READ_LAT]),
    .push_data (bus.mem_q),
    .pop       (pop),
    .occupancy (occupancy),
    .rd_data   (fifo_data),
    .rd_valid  (fifo_valid)
  );

  assign bus.mem_address = mem_address_q;
  assign bus.mem_wren    = 1'b0;
  assign bus.mem_data    = '0;
  assign bus.out_data    = fifo_data;
  assign bus.out_valid   = fifo_valid;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = zero_done_q | final_pop;

endmodule

// File: tb/tb_dram_stream_reader.sv
// Bench for dram_stream_reader: DRAM model with fixed read latency, stream monitor,
// and reference expectations computed as mem[(base + i*stride) mod 2^17].
module tb_dram_stream_reader;
  localparam int unsigned READ_LAT   = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned MEM_WORDS  = 131072;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  dram_stream_reader_if bus ();

  dram_stream_reader #(
    .READ_LAT   (READ_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // DRAM: address seen after an edge returns data READ_LAT edges later.
  logic [7:0] dram [MEM_WORDS];
  logic [7:0] rd_pipe [READ_LAT];
  always @(posedge clock) begin
    rd_pipe[0] <= dram[bus.mem_address];
    for (int unsigned i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_q = rd_pipe[READ_LAT-1];

  // Stream monitor: accepted elements, done pulses, hold-stability violations.
  logic [7:0]  got [$];
  int unsigned done_cnt = 0;
  int unsigned stab_err = 0;
  logic        prev_hold = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  always @(negedge clock) begin
    if (reset_n && prev_hold && !(bus.out_valid === 1'b1 && bus.out_data === prev_data))
      stab_err <= stab_err + 1;
    prev_hold <= reset_n && bus.out_valid && !bus.out_ready;
    prev_data <= bus.out_data;
    if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [16:0] eff_stride(input logic [16:0] s);
`ifdef DRAM_STREAM_STRIDE_EN
    return s;
`else
    return (s == s) ? 17'd1 : 17'd1;
`endif
  endfunction

  // One transfer. mode: 0 ready high, 1 ready 1,0,0 repeating, 2 random.
  // hold: ready forced low for that many cycles first. poke: stray start mid-transfer.
  task automatic run_xfer(input string tag, input logic [16:0] base, input logic [16:0] cnt,
                          input logic [16:0] strd, input int unsigned mode,
                          input int unsigned hold, input bit poke, output int unsigned first);
    int unsigned d0    = done_cnt;
    int unsigned cyc   = 0;
    int unsigned limit = 32'(cnt) * 20 + 60 + hold;
    logic [16:0] inc   = eff_stride(strd);
    logic [7:0]  exp_q [$];
    int unsigned a;
    first = got.size();
    for (int unsigned i = 0; i < 32'(cnt); i++) begin
      a = (32'(base) + i * 32'(inc)) & 32'h1FFFF;
      exp_q.push_back(dram[17'(a)]);
    end
    bus.base_addr = base;
    bus.count     = cnt;
    bus.stride    = strd;
    bus.start     = 1'b1;
    bus.out_ready = (hold == 0);
    tick();
    bus.start     = 1'b0;
    bus.base_addr = 17'($urandom);
    bus.count     = 17'($urandom_range(1, 9));
    bus.stride    = 17'($urandom);
    while (done_cnt == d0 && cyc < limit) begin
      if (cyc < hold)     bus.out_ready = 1'b0;
      else if (mode == 1) bus.out_ready = (cyc % 3 == 0);
      else if (mode == 2) bus.out_ready = 1'($urandom_range(0, 1));
      else                bus.out_ready = 1'b1;
      bus.start = poke && (cyc == 3);
      tick();
      cyc++;
      if (hold != 0 && cyc == hold) begin
        a = (32'(base) + (FIFO_DEPTH - 1) * 32'(inc)) & 32'h1FFFF;
        check({tag, "_stall_addr"}, 32'(bus.mem_address), a);
      end
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    check({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    repeat (6) tick();
    check({tag, "_count"}, got.size() - first, 32'(cnt));
    for (int unsigned i = 0; i < 32'(cnt) && first + i < got.size(); i++)
      check({tag, "_elem"}, 32'(got[first + i]), 32'(exp_q[i]));
    check({tag, "_done_once"}, done_cnt - d0, 32'd1);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int unsigned first;
    int unsigned d0;
    logic [16:0] addr0;

    for (int unsigned a = 0; a < MEM_WORDS; a++) dram[a] = a[7:0];
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.count     = '0;
    bus.stride    = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check("rst_addr",  32'(bus.mem_address), 32'd0);
    check("rst_wren",  32'(bus.mem_wren),    32'd0);
    check("rst_mdata", 32'(bus.mem_data),    32'd0);
    check("rst_odata", 32'(bus.out_data),    32'd0);
    check("rst_valid", 32'(bus.out_valid),   32'd0);
    check("rst_busy",  32'(bus.busy),        32'd0);
    check("rst_done",  32'(bus.done),        32'd0);
    reset_n = 1'b1;
    tick();

    // Contiguous read with exact cycle timing: start sampled at T0.
    bus.base_addr = 17'd5;
    bus.count     = 17'd4;
    bus.stride    = 17'd1;
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    check("c_busy_t0", 32'(bus.busy), 32'd1);
    for (int unsigned k = 1; k <= 8; k++) begin
      tick();
      check("c_addr",  32'(bus.mem_address), 5 + ((k < 4) ? k - 1 : 3));
      check("c_valid", 32'(bus.out_valid),   32'(k >= 4 && k <= 7));
      check("c_done",  32'(bus.done),        32'(k == 7));
      check("c_busy",  32'(bus.busy),        32'(k <= 7));
      if (k >= 4 && k <= 7) check("c_data", 32'(bus.out_data), k + 1);
    end
    tick();

    run_xfer("stride", 17'd0, 17'd3, 17'd100, 0, 0, 1'b0, first);
`ifdef DRAM_STREAM_STRIDE_EN
    check("stride_third", 32'(got[first + 2]), 32'h0000_00C8);
`else
    check("stride_third", 32'(got[first + 2]), 32'h0000_0002);
`endif
    run_xfer("wrap", 17'h1FFFE, 17'd4, 17'd1, 0, 0, 1'b0, first);
    run_xfer("bp",   17'h00040, 17'd8, 17'd1, 1, 0, 1'b0, first);
    run_xfer("stall", 17'h00080, 17'd8, 17'd1, 0, 10, 1'b0, first);
    run_xfer("poke",  17'h00300, 17'd9, 17'd2, 1, 0, 1'b1, first);

    // Zero-length request: done next cycle, no reads, no elements.
    first         = got.size();
    addr0         = bus.mem_address;
    bus.base_addr = 17'h00123;
    bus.count     = 17'd0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    check("zero_done", 32'(bus.done), 32'd1);
    check("zero_busy", 32'(bus.busy), 32'd0);
    tick();
    check("zero_done_clr", 32'(bus.done),        32'd0);
    check("zero_addr",     32'(bus.mem_address), 32'(addr0));
    repeat (5) tick();
    check("zero_no_elem", got.size() - first, 32'd0);

    // Reset while draining with the consumer stalled.
    bus.base_addr = 17'h00100;
    bus.count     = 17'd3;
    bus.stride    = 17'd1;
    bus.out_ready = 1'b0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    check("mid_busy",  32'(bus.busy),      32'd1);
    check("mid_valid", 32'(bus.out_valid), 32'd1);
    first   = got.size();
    d0      = done_cnt;
    reset_n = 1'b0;
    #1;
    check("mrst_addr",  32'(bus.mem_address), 32'd0);
    check("mrst_odata", 32'(bus.out_data),    32'd0);
    check("mrst_valid", 32'(bus.out_valid),   32'd0);
    check("mrst_busy",  32'(bus.busy),        32'd0);
    check("mrst_done",  32'(bus.done),        32'd0);
    bus.out_ready = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    check("mrst_no_elem", got.size() - first, 32'd0);
    check("mrst_no_done", done_cnt - d0, 32'd0);
    run_xfer("after_rst", 17'h00200, 17'd5, 17'd1, 0, 0, 1'b0, first);

    // Random memory contents, requests and consumer behaviour.
    for (int unsigned a = 0; a < MEM_WORDS; a++) dram[a] = 8'($urandom);
    for (int unsigned t = 0; t < 6; t++)
      run_xfer("rand", 17'($urandom), 17'($urandom_range(1, 20)), 17'($urandom),
               $urandom_range(0, 2), 0, 1'b0, first);

    check("hold_stable", stab_err, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dram_stream_reader.md
# dram_stream_reader

Read-side sequencer sitting directly upstream of the compute datapath and directly downstream of the `DRAM` single-port memory (17-bit address, 8-bit data). Given a base address, element count and stride, it issues back-to-back DRAM reads, absorbs the fixed memory read latency, and presents elements in order on a valid/ready stream. It is the block the matrix-multiply controller uses to pull rows and columns of an operand matrix.

## Interface
Parameters:
- `READ_LAT`, default 2: DRAM read latency in cycles, from address presented to `mem_q` valid.
- `FIFO_DEPTH`, default 4: output buffer entries. Must be ≥ `READ_LAT`+1 for full throughput; must be a power of two.

Ports:
- `clock`  in  1  sole clock; rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a transfer; sampled only in IDLE.
- `base_addr`  in  17  first element address; captured with `start`.
- `count`  in  17  number of elements; captured with `start`.
- `stride`  in  17  address increment between elements; captured with `start`.
- `mem_address`  out  17  to `DRAM.address`.
- `mem_wren`  out  1  to `DRAM.wren`; constant 0.
- `mem_data`  out  8  to `DRAM.data`; constant 0.
- `mem_q`  in  8  from `DRAM.q`.
- `out_data`  out  8  stream element.
- `out_valid`  out  1  `out_data` holds a valid element.
- `out_ready`  in  1  consumer accepts the element this cycle.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse when the final element is accepted.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: `start`=1 captures `base_addr`/`count`/`stride`. If `count`=0, pulse `done` next cycle and stay IDLE. Otherwise go to ISSUE.
- ISSUE: a read issues in any cycle where `occupancy + inflight < FIFO_DEPTH`. Each issue drives `mem_address`, then advances the address by `stride` modulo 2^17 (wrap silently) and decrements the remaining count. When the last read issues, go to DRAIN.
- A `READ_LAT`-deep valid shift register tracks reads in flight. When a tagged slot emerges, `mem_q` is written into the FIFO.
- DRAIN: wait until inflight=0 and the FIFO is empty. The final pop (`out_valid && out_ready`) pulses `done`. Return to IDLE the same cycle.
- `start` while not in IDLE is ignored.
- FIFO push and pop in the same cycle are legal; occupancy is then unchanged. Simultaneous push and pop on a full FIFO is legal because the credit check already reserved the slot.
- Elements leave in issue order. No element is dropped or duplicated under any `out_ready` pattern.

## Timing
- Reset values: `mem_address`=0, `mem_wren`=0, `mem_data`=0, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0. State is IDLE; FIFO, inflight pipe and counters are cleared.
- Reset mid-transfer aborts the transfer. Returns still in flight are discarded.
- `start` is sampled at edge T0. The first address is driven from T1. `out_valid` first rises at T1+`READ_LAT`+1 (T4 with defaults).
- With `out_ready` held high and `FIFO_DEPTH` ≥ `READ_LAT`+1, throughput is one element per cycle. N elements complete with `done` at T0+`READ_LAT`+N+1.
- `out_data` and `out_valid` are registered FIFO outputs and are stable while `out_valid && !out_ready`.

## Configuration
- `DRAM_STREAM_STRIDE_EN` defined: the `stride` port is honoured as described.
- Not defined: the `stride` port is present but ignored, and the increment is fixed at 1. Stride capture logic is removed; the port list is unchanged.

## Structure
- Shared package holds:
  - `DRAM_ADDR_W`=17 and `DRAM_DATA_W`=8;
  - the state enum (IDLE/ISSUE/DRAIN);
  - a `dram_addr_t` typedef.
- One sub-module, `stream_fifo`: synchronous FIFO parameterised by depth and width, with push/pop/occupancy and registered outputs.

## Test plan
- Contiguous read: DRAM preloaded with value = address[7:0]; `base_addr`=5, `count`=4, `stride`=1, `out_ready`=1. Expect outputs 05,06,07,08 on consecutive cycles, first `out_valid` at T4, `done` at T7.
- Strided read (macro defined): `base_addr`=0, `count`=3, `stride`=100. Expect addresses 0,100,200 and data 00,64,C8. With the macro undefined, expect data 00,01,02.
- Backpressure: `count`=8, `out_ready` toggling 1,0,0,1,… Expect all 8 values in order, none lost. `mem_address` stalls while the FIFO plus in-flight reads reach 4.
- Wrap-around: `base_addr`=0x1FFFE, `count`=4, `stride`=1. Expect addresses 1FFFE,1FFFF,00000,00001.
- Boundaries: `count`=0 gives a `done` pulse one cycle after `start` with no reads issued. A `start` asserted mid-transfer is ignored.
- Reset mid-transfer: assert `reset_n`=0 during DRAIN. All outputs return to reset values immediately. A new transfer afterwards yields correct data with no stale elements.
